// File: rtl/rp_bus_arb.sv
// Shares one memory port between the program-fetch bus and the data bus.
// Data wins contention unless a fetch has waited MAXWAIT cycles; grants lock across memory stalls.
module rp_bus_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int MAXWAIT = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_bup_req,
  input  logic [AW-1:0] i_bup_adr,
  output logic [DW-1:0] o_bup_rdt,
  output logic          o_bup_ack,
  input  logic          i_bud_req,
  input  logic          i_bud_wen,
  input  logic [SW-1:0] i_bud_sel,
  input  logic [AW-1:0] i_bud_adr,
  input  logic [DW-1:0] i_bud_wdt,
  output logic [DW-1:0] o_bud_rdt,
  output logic          o_bud_ack,
  output logic          o_bum_req,
  output logic          o_bum_wen,
  output logic [SW-1:0] o_bum_sel,
  output logic [AW-1:0] o_bum_adr,
  output logic [DW-1:0] o_bum_wdt,
  input  logic [DW-1:0] i_bum_rdt,
  input  logic          i_bum_ack,
  output logic [1:0]    o_state
);

  // Handshake on every bus: a transfer happens in any cycle where req and ack are
  // both high; ack has no meaning without req, and read data is on rdt one cycle later.

  localparam int WW = $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] MAXW = WW'(MAXWAIT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_P = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [1:0]    r_state;
  logic [WW-1:0] r_wait_cnt;
  logic [1:0]    r_rd_own;
  logic [DW-1:0] r_hold_p;
  logic [DW-1:0] r_hold_d;

  logic w_grant_p;
  logic w_grant_d;
  logic w_xfer_p;
  logic w_xfer_d;
  logic w_rd_d;

  // A locked port keeps the grant only while it still requests; dropping req releases it.
  always_comb begin
    w_grant_p = 1'b0;
    w_grant_d = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_LOCK_P: w_grant_p = i_bup_req;
        ST_LOCK_D: w_grant_d = i_bud_req;
        default: begin
          if (i_bup_req && i_bud_req) begin
            if (r_wait_cnt == MAXW) w_grant_p = 1'b1;
            else                    w_grant_d = 1'b1;
          end else begin
            w_grant_p = i_bup_req;
            w_grant_d = i_bud_req;
          end
        end
      endcase
    end
  end

  assign w_xfer_p = w_grant_p & i_bum_ack;
  assign w_xfer_d = w_grant_d & i_bum_ack;
  assign w_rd_d   = w_xfer_d & ~i_bud_wen;

  assign o_bum_req = w_grant_p | w_grant_d;
  assign o_bum_wen = w_grant_d & i_bud_wen;
  assign o_bum_sel = w_grant_p ? {SW{1'b1}} : (w_grant_d ? i_bud_sel : '0);
  assign o_bum_adr = w_grant_p ? i_bup_adr : (w_grant_d ? i_bud_adr : '0);
  assign o_bum_wdt = w_grant_d ? i_bud_wdt : '0;

  assign o_bup_ack = w_xfer_p;
  assign o_bud_ack = w_xfer_d;

  assign o_bup_rdt = i_rst ? '0 : ((r_rd_own == OWN_P) ? i_bum_rdt : r_hold_p);
  assign o_bud_rdt = i_rst ? '0 : ((r_rd_own == OWN_D) ? i_bum_rdt : r_hold_d);

  assign o_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_LOCK_P: r_state <= (!i_bup_req || i_bum_ack) ? ST_IDLE : ST_LOCK_P;
        ST_LOCK_D: r_state <= (!i_bud_req || i_bum_ack) ? ST_IDLE : ST_LOCK_D;
        default: begin
          if (w_grant_p && !i_bum_ack)      r_state <= ST_LOCK_P;
          else if (w_grant_d && !i_bum_ack) r_state <= ST_LOCK_D;
          else                              r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles a requesting fetch has gone without a transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_bup_req || w_xfer_p) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != MAXW) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_own <= OWN_NONE;
      r_hold_p <= '0;
      r_hold_d <= '0;
    end else begin
      if (w_xfer_p)    r_rd_own <= OWN_P;
      else if (w_rd_d) r_rd_own <= OWN_D;
      else             r_rd_own <= OWN_NONE;
      if (r_rd_own == OWN_P) r_hold_p <= i_bum_rdt;
      if (r_rd_own == OWN_D) r_hold_d <= i_bum_rdt;
    end
  end

endmodule

// File: tb/tb_rp_bus_arb.sv
// Bench for rp_bus_arb: a simple memory answers the shared port while a
// rule-level model predicts grants, acks and each port's last read value.
module tb_rp_bus_arb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MAXWAIT = 3;
  localparam int BW = 2 + SW + AW + DW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          bup_req;
  logic [AW-1:0] bup_adr;
  logic [DW-1:0] bup_rdt;
  logic          bup_ack;
  logic          bud_req;
  logic          bud_wen;
  logic [SW-1:0] bud_sel;
  logic [AW-1:0] bud_adr;
  logic [DW-1:0] bud_wdt;
  logic [DW-1:0] bud_rdt;
  logic          bud_ack;
  logic          bum_req;
  logic          bum_wen;
  logic [SW-1:0] bum_sel;
  logic [AW-1:0] bum_adr;
  logic [DW-1:0] bum_wdt;
  logic [DW-1:0] bum_rdt;
  logic          bum_ack;
  logic [1:0]    dbg_state;

  rp_bus_arb #(.AW(AW), .DW(DW), .SW(SW), .MAXWAIT(MAXWAIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_bup_req(bup_req), .i_bup_adr(bup_adr), .o_bup_rdt(bup_rdt), .o_bup_ack(bup_ack),
    .i_bud_req(bud_req), .i_bud_wen(bud_wen), .i_bud_sel(bud_sel), .i_bud_adr(bud_adr),
    .i_bud_wdt(bud_wdt), .o_bud_rdt(bud_rdt), .o_bud_ack(bud_ack),
    .o_bum_req(bum_req), .o_bum_wen(bum_wen), .o_bum_sel(bum_sel), .o_bum_adr(bum_adr),
    .o_bum_wdt(bum_wdt), .i_bum_rdt(bum_rdt), .i_bum_ack(bum_ack),
    .o_state(dbg_state)
  );

  // memory environment: read data one cycle after a read transfer, noise otherwise
  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] ref_mem [0:511];
  logic [DW-1:0] mem_rdt;
  logic          mem_load;
  assign bum_rdt = mem_rdt;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) mem[i] <= ref_mem[i];
      mem_rdt <= $urandom;
    end else if (bum_req && bum_ack) begin
      if (bum_wen) begin
        for (int b = 0; b < SW; b++)
          if (bum_sel[b]) mem[bum_adr[8:0]][8*b +: 8] <= bum_wdt[8*b +: 8];
        mem_rdt <= $urandom;
      end else begin
        mem_rdt <= mem[bum_adr[8:0]];
      end
    end else begin
      mem_rdt <= $urandom;
    end
  end

  // reference model state: lock owner (0 none, 1 program, 2 data), fetch wait, last reads
  int checks = 0;
  int errors = 0;
  int m_lock, m_wait, m_g;
  logic [DW-1:0] m_p_last, m_d_last;
  logic [BW-1:0] exp_bus;
  logic [2*DW-1:0] exp_rdt;

  function automatic logic [BW-1:0] got_bus();
    return {bum_req, bum_wen, bum_sel, bum_adr, bum_wdt, bup_ack, bud_ack};
  endfunction

  // driver: apply inputs for one cycle and compute the expected outputs
  task automatic apply(input logic r, input logic pr, input logic [AW-1:0] pa,
                       input logic dr, input logic dw, input logic [SW-1:0] ds,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd, input logic ack);
    rst = r; bup_req = pr; bup_adr = pa;
    bud_req = dr; bud_wen = dw; bud_sel = ds; bud_adr = da; bud_wdt = dd;
    bum_ack = ack;
    if (r)                m_g = 0;
    else if (m_lock == 1) m_g = pr ? 1 : 0;
    else if (m_lock == 2) m_g = dr ? 2 : 0;
    else if (pr && dr)    m_g = (m_wait == MAXWAIT) ? 1 : 2;
    else                  m_g = pr ? 1 : (dr ? 2 : 0);
    case (m_g)
      1:       exp_bus = {1'b1, 1'b0, {SW{1'b1}}, pa, {DW{1'b0}}, ack, 1'b0};
      2:       exp_bus = {1'b1, dw, ds, da, dd, 1'b0, ack};
      default: exp_bus = '0;
    endcase
    exp_rdt = r ? '0 : {m_p_last, m_d_last};
    #3;
  endtask

  // advance the model across the clock edge, then move to the next drive point
  task automatic advance();
    if (rst) begin
      m_lock = 0; m_wait = 0; m_p_last = '0; m_d_last = '0;
    end else begin
      if (m_g == 1 && bum_ack) m_p_last = ref_mem[bup_adr[8:0]];
      if (m_g == 2 && bum_ack) begin
        if (bud_wen) begin
          for (int b = 0; b < SW; b++)
            if (bud_sel[b]) ref_mem[bud_adr[8:0]][8*b +: 8] = bud_wdt[8*b +: 8];
        end else begin
          m_d_last = ref_mem[bud_adr[8:0]];
        end
      end
      if (!bup_req || (m_g == 1 && bum_ack)) m_wait = 0;
      else if (m_wait < MAXWAIT)             m_wait = m_wait + 1;
      m_lock = (m_g != 0 && !bum_ack) ? m_g : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    mem_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, AW'($urandom_range(0, 15)), 1'b1, 1'($urandom), SW'($urandom),
            AW'($urandom_range(0, 15)), $urandom, 1'b1);
      if (got_bus() !== exp_bus) begin
        errors++; $display("FAIL reset_bus got %h exp %h", got_bus(), exp_bus);
      end
      checks++;
      if ({bup_rdt, bud_rdt} !== exp_rdt) begin
        errors++; $display("FAIL reset_rdt got %h exp %h", {bup_rdt, bud_rdt}, exp_rdt);
      end
      checks++;
      advance();
      mem_load = 1'b0;
    end
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", dbg_state);
    end
    checks++;
  endtask

  task automatic test_single_port();
    apply(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    if (got_bus() !== exp_bus || bum_adr !== 16'h0010 || bup_ack !== 1'b1) begin
      errors++; $display("FAIL single_bus got %h exp %h", got_bus(), exp_bus);
    end
    checks++;
    advance();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    if (bup_rdt !== 32'h12345678 || bud_rdt !== 32'h0) begin
      errors++; $display("FAIL single_rdt got %h %h exp 12345678 0", bup_rdt, bud_rdt);
    end
    checks++;
    advance();
  endtask

  task automatic test_contention();
    idle_cycle();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, AW'($urandom_range(0, 15)), 1'b1, 1'b0, '1,
            AW'($urandom_range(0, 15)), $urandom, 1'b1);
      if (got_bus() !== exp_bus) begin
        errors++; $display("FAIL contend_bus cyc %0d got %h exp %h", i, got_bus(), exp_bus);
      end
      checks++;
      if (bup_ack !== ((i % 4) == 3) || bud_ack !== ((i % 4) != 3)) begin
        errors++; $display("FAIL contend_order cyc %0d got p%b d%b", i, bup_ack, bud_ack);
      end
      checks++;
      if ({bup_rdt, bud_rdt} !== exp_rdt) begin
        errors++; $display("FAIL contend_rdt got %h exp %h", {bup_rdt, bud_rdt}, exp_rdt);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_stall_lock();
    idle_cycle();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 4'b1010, 16'h0020, 32'hCAFEF00D, i >= 4);
      if (got_bus() !== exp_bus) begin
        errors++; $display("FAIL stall_bus cyc %0d got %h exp %h", i, got_bus(), exp_bus);
      end
      checks++;
      if (i < 5) begin
        if (bum_adr !== 16'h0020 || bum_wen !== 1'b1 || bum_sel !== 4'b1010 ||
            bum_wdt !== 32'hCAFEF00D || bup_ack !== 1'b0 || bud_ack !== (i == 4)) begin
          errors++; $display("FAIL stall_lock cyc %0d got adr %h ack p%b d%b", i, bum_adr, bup_ack, bud_ack);
        end
      end else begin
        if (bup_ack !== 1'b1 || bud_ack !== 1'b0 || bum_adr !== 16'h0004) begin
          errors++; $display("FAIL stall_after got adr %h ack p%b d%b exp 0004 p1 d0", bum_adr, bup_ack, bud_ack);
        end
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] prev;
    idle_cycle();
    prev = m_d_last;
    apply(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'b0011, 16'h0040, 32'hAAAA5555, 1'b1);
    if (got_bus() !== exp_bus || bud_ack !== 1'b1) begin
      errors++; $display("FAIL wr_bus got %h exp %h", got_bus(), exp_bus);
    end
    checks++;
    advance();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'b1111, 16'h0040, 32'h0, 1'b1);
    if (bud_rdt !== prev) begin
      errors++; $display("FAIL wr_rdt_hold got %h exp %h", bud_rdt, prev);
    end
    checks++;
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, AW'(i), 1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (bud_rdt !== 32'h11225555) begin
        errors++; $display("FAIL rd_merge cyc %0d got %h exp 11225555", i, bud_rdt);
      end
      checks++;
      if (got_bus() !== exp_bus || {bup_rdt, bud_rdt} !== exp_rdt) begin
        errors++; $display("FAIL rd_follow cyc %0d got %h exp %h", i, {bup_rdt, bud_rdt}, exp_rdt);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_interleaved();
    logic [DW-1:0] m0, m100;
    m0 = ref_mem[0];
    m100 = ref_mem[9'h100];
    idle_cycle();
    apply(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    advance();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'b1111, 16'h0100, '0, 1'b1);
    if (bup_rdt !== m0 || bud_ack !== 1'b1) begin
      errors++; $display("FAIL inter_p got %h exp %h", bup_rdt, m0);
    end
    checks++;
    advance();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    if (bud_rdt !== m100 || bup_rdt !== m0) begin
      errors++; $display("FAIL inter_d got %h %h exp %h %h", bup_rdt, bud_rdt, m0, m100);
    end
    checks++;
    advance();
  endtask

  task automatic test_reset_mid_stall();
    idle_cycle();
    apply(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    advance();
    apply(1'b0, 1'b1, 16'h0008, 1'b1, 1'b0, '1, 16'h0009, '0, 1'b0);
    if (got_bus() !== exp_bus || bum_adr !== 16'h0008) begin
      errors++; $display("FAIL midrst_lock got %h exp %h", got_bus(), exp_bus);
    end
    checks++;
    advance();
    apply(1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, '1, 16'h0009, '0, 1'b1);
    if (got_bus() !== '0 || {bup_rdt, bud_rdt} !== '0) begin
      errors++; $display("FAIL midrst_during got %h rdt %h exp 0", got_bus(), {bup_rdt, bud_rdt});
    end
    checks++;
    advance();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    if (bum_req !== 1'b0 || bup_ack !== 1'b0 || bud_ack !== 1'b0 || {bup_rdt, bud_rdt} !== '0) begin
      errors++; $display("FAIL midrst_after got req %b rdt %h exp 0", bum_req, {bup_rdt, bud_rdt});
    end
    checks++;
    advance();
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, '1, 16'h000C, '0, 1'b1);
    if (bud_ack !== 1'b1 || bum_adr !== 16'h000C) begin
      errors++; $display("FAIL midrst_fresh got ack %b adr %h exp 1 000c", bud_ack, bum_adr);
    end
    checks++;
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), 1'($urandom), SW'($urandom), AW'($urandom_range(0, 15)),
            $urandom, ($urandom_range(0, 9) < 6));
      if (got_bus() !== exp_bus) begin
        errors++; $display("FAIL rand_bus cyc %0d got %h exp %h", i, got_bus(), exp_bus);
      end
      checks++;
      if ({bup_rdt, bud_rdt} !== exp_rdt) begin
        errors++; $display("FAIL rand_rdt cyc %0d got %h exp %h", i, {bup_rdt, bud_rdt}, exp_rdt);
      end
      checks++;
      advance();
    end
  endtask

  initial begin
    m_lock = 0; m_wait = 0; m_g = 0; m_p_last = '0; m_d_last = '0;
    mem_load = 1'b1;
    rst = 1'b1; bup_req = 1'b0; bup_adr = '0; bud_req = 1'b0; bud_wen = 1'b0;
    bud_sel = '0; bud_adr = '0; bud_wdt = '0; bum_ack = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = $urandom;
    ref_mem[9'h010] = 32'h12345678;
    ref_mem[9'h040] = 32'h11223344;
    @(posedge clk);
    #1;
    test_reset();
    test_single_port();
    test_contention();
    test_stall_lock();
    test_write_read();
    test_interleaved();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rp_bus_arb.md
# rp_bus_arb

Two-port to one-port bus arbiter that lets the rp32_core program-fetch bus and data bus share a single unified memory. It sits between the core and one `mem` instance and adds no latency on an uncontended bus. Data accesses have priority, with a bounded-starvation override for fetches. A grant stays locked through memory stalls, and returned read data is steered and held per port.

## Interface
- AW, 16, address width, shared by both ports and memory
- DW, 32, data width
- SW, DW/8, byte-select width
- MAXWAIT, 3, max consecutive cycles a contended fetch may wait before it gains priority (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- bup_req  in  1  program request
- bup_adr  in  AW  program address
- bup_rdt  out  DW  program read data
- bup_ack  out  1  program acknowledge
- bud_req  in  1  data request
- bud_wen  in  1  data write enable
- bud_sel  in  SW  data byte select
- bud_adr  in  AW  data address
- bud_wdt  in  DW  data write data
- bud_rdt  out  DW  data read data
- bud_ack  out  1  data acknowledge
- bum_req, bum_wen  out  1  memory request, write enable
- bum_sel  out  SW  memory byte select
- bum_adr  out  AW  memory address
- bum_wdt  out  DW  memory write data
- bum_rdt  in  DW  memory read data
- bum_ack  in  1  memory acknowledge

## Operation
- Protocol on all buses: a transfer occurs in any cycle with req&ack. Read data is valid on rdt in the cycle after a read transfer.
- Program port is always a full-word read: bum_wen=0, bum_sel='1, bum_wdt=0 when it is granted.
- FSM states: IDLE, LOCK_P, LOCK_D.
- IDLE, neither port requesting: no grant, bum_req=0.
- IDLE, one port requesting: that port is granted.
- IDLE, both ports requesting: data is granted unless wait_cnt==MAXWAIT, in which case program is granted.
- IDLE → LOCK_x: port x is granted and bum_ack=0.
- LOCK_x: grant is forced to x, whatever the other port does. Go to IDLE when bum_ack=1.
- Protocol violation in LOCK_x (x drops req): go to IDLE. bum_req=0 that cycle, and no ack is issued.
- Granted port's signals pass combinationally to bum_*.
- bup_ack = grant_p & bum_ack; bud_ack = grant_d & bum_ack. The non-granted port's ack is 0.
- With no grant, bum_* outputs are 0.
- wait_cnt, width $clog2(MAXWAIT+1):
  - clears to 0 on a program transfer or when bup_req=0;
  - otherwise increments, saturating at MAXWAIT.
- rd_own register (NONE/P/D): on each cycle, loads P for a program transfer, D for a data read transfer (wen=0), NONE otherwise. Data writes load NONE.
- Read-data steering:
  - bup_rdt = (rd_own==P) ? bum_rdt : hold_p;
  - bud_rdt = (rd_own==D) ? bum_rdt : hold_d;
  - hold_x captures bum_rdt whenever rd_own==x, so each port's rdt stays stable until its next read.

## Timing
- Reset (rst=1 at clk edge):
  - state=IDLE, wait_cnt=0, rd_own=NONE, hold_p=hold_d=0.
  - While rst=1, grant is forced off: bum_req=0, bup_ack=bud_ack=0, all bum_* = 0, bup_rdt=bud_rdt=0.
- Reset mid-stall abandons the locked transfer. No ack is issued for it.
- Request-to-memory path is combinational, with zero added latency. Ack is combinational from bum_ack.
- Read data reaches the owning port in the same cycle memory drives it (transfer + 1). Back-to-back transfers, including alternating ports, sustain 1 per cycle.
- Worst-case fetch wait under continuous data traffic with bum_ack=1: MAXWAIT cycles, fetch transfers on cycle MAXWAIT+1.
- A locked stall can delay it further; wait_cnt saturates and does not wrap.

## Test plan
- Single port: bup_req only, bup_adr=0x0010, mem word 0x12345678, bum_ack=1 → bum_adr=0x0010 same cycle, bup_ack=1, bup_rdt=0x12345678 next cycle. bud_rdt stays 0.
- Contention: both ports request continuously, bum_ack=1, MAXWAIT=3 → data transfers on cycles 0,1,2, program on cycle 3, wait_cnt back to 0; pattern repeats D,D,D,P.
- Stall lock: data granted with bum_ack=0 for 4 cycles while bup_req asserts → bum_adr/wen/sel/wdt equal data values for all 5 cycles, bup_ack=0. Data transfer happens on cycle 5, then program is granted.
- Write then read, data port: write sel=4'b0011, wdt=0xAAAA5555 to 0x0040 → bud_ack=1, rd_own=NONE, bud_rdt unchanged. Read 0x0040 → bud_rdt shows the write merged into the existing word next cycle, then holds that value while the following program reads occur.
- Interleaved reads: P@0x0000 then D@0x0100 on consecutive cycles → bup_rdt = mem[0] on cycle 1 and held afterwards; bud_rdt = mem[0x100] on cycle 2.
- Reset mid-stall: rst=1 while in LOCK_P → next cycle bum_req=0, both acks 0, both rdt 0. After rst deasserts, a fresh bud_req is granted immediately.
